// File: rtl/mips_pip_cpu.sv
// Five-stage pipelined MIPS subset core: IF/ID/EX/MEM/WB with forwarding,
// load-use stall, j resolved in ID, beq resolved in EX, and precise EX exceptions.
module mips_pip_cpu #(
  parameter int MEM_SIZE      = 512,
  parameter int ExceptionAddr = MEM_SIZE - 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic [4:0]  RegisterNo,
  output logic [31:0] RegisterContent,
  output logic [31:0] DataAddr,
  output logic [31:0] Data
);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction

  function automatic logic sub_ovf(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d);
    return (a[31] != b[31]) && (d[31] != a[31]);
  endfunction

  logic [31:0] pc;
  logic [31:0] if_id_instr, if_id_pc;
  logic [31:0] id_ex_pc, id_ex_a, id_ex_b, id_ex_imm;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_dst;
  logic        id_ex_memread, id_ex_memwrite, id_ex_branch, id_ex_alusrc, id_ex_ovf, id_ex_illegal;
  alu_op_t     id_ex_aluop;
  logic [31:0] ex_mem_alu, ex_mem_daddr, ex_mem_ddata;
  logic [4:0]  ex_mem_dst;
  logic        ex_mem_memread, ex_mem_memwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_val;
  logic [31:0] epc;
  logic [31:0] regs [32];
  // Data memory powers up zeroed and is deliberately left untouched by reset.
  logic [31:0] dmem [64] = '{default: 32'd0};

  logic [5:0]  id_op, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_imm, id_a, id_b, jump_target;
  logic [4:0]  dec_dst;
  logic        dec_memread, dec_memwrite, dec_branch, dec_alusrc, dec_ovf, dec_illegal, dec_jump;
  logic        uses_rs, uses_rt, stall;
  alu_op_t     dec_aluop;

  assign id_op       = if_id_instr[31:26];
  assign id_rs       = if_id_instr[25:21];
  assign id_rt       = if_id_instr[20:16];
  assign id_rd       = if_id_instr[15:11];
  assign id_funct    = if_id_instr[5:0];
  assign id_imm      = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
  assign jump_target = {4'((if_id_pc + 32'd4) >> 28), if_id_instr[25:0], 2'b00};

  // Instruction decode; destination is 0 whenever the instruction does not write.
  always_comb begin
    dec_dst = 5'd0; dec_memread = 1'b0; dec_memwrite = 1'b0; dec_branch = 1'b0;
    dec_alusrc = 1'b0; dec_ovf = 1'b0; dec_illegal = 1'b0; dec_jump = 1'b0;
    uses_rs = 1'b0; uses_rt = 1'b0; dec_aluop = ALU_ADD;
    case (id_op)
      6'h00: begin
        if (if_id_instr != 32'd0) begin
          uses_rs = 1'b1; uses_rt = 1'b1; dec_dst = id_rd;
          case (id_funct)
            6'h20: begin dec_aluop = ALU_ADD; dec_ovf = 1'b1; end
            6'h22: begin dec_aluop = ALU_SUB; dec_ovf = 1'b1; end
            6'h24: dec_aluop = ALU_AND;
            6'h25: dec_aluop = ALU_OR;
            6'h2A: dec_aluop = ALU_SLT;
            default: begin dec_illegal = 1'b1; dec_dst = 5'd0; end
          endcase
        end else begin
          dec_dst = 5'd0;
        end
      end
      6'h08: begin dec_dst = id_rt; dec_alusrc = 1'b1; dec_ovf = 1'b1; uses_rs = 1'b1; end
      6'h23: begin dec_dst = id_rt; dec_alusrc = 1'b1; dec_memread = 1'b1; uses_rs = 1'b1; end
      6'h2B: begin dec_alusrc = 1'b1; dec_memwrite = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
      6'h04: begin dec_branch = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
      6'h02: dec_jump = 1'b1;
      default: dec_illegal = 1'b1;
    endcase
  end

  // Register read with same-cycle bypass of the value being written in WB.
  always_comb begin
    if (id_rs == 5'd0)       id_a = 32'd0;
    else if (wb_rd == id_rs) id_a = wb_val;
    else                     id_a = regs[id_rs];
    if (id_rt == 5'd0)       id_b = 32'd0;
    else if (wb_rd == id_rt) id_b = wb_val;
    else                     id_b = regs[id_rt];
  end

  assign stall = id_ex_memread && (id_ex_dst != 5'd0) &&
                 ((uses_rs && (id_ex_dst == id_rs)) || (uses_rt && (id_ex_dst == id_rt)));

  logic [31:0] fwd_a, fwd_b, op_b, alu_out, branch_target, seq_pc, next_pc;
  logic        overflow, exc, taken;

  // EX operand forwarding: the younger EX/MEM result wins over MEM/WB.
  always_comb begin
    if ((ex_mem_dst != 5'd0) && (ex_mem_dst == id_ex_rs)) fwd_a = ex_mem_alu;
    else if ((wb_rd != 5'd0) && (wb_rd == id_ex_rs))      fwd_a = wb_val;
    else                                                  fwd_a = id_ex_a;
    if ((ex_mem_dst != 5'd0) && (ex_mem_dst == id_ex_rt)) fwd_b = ex_mem_alu;
    else if ((wb_rd != 5'd0) && (wb_rd == id_ex_rt))      fwd_b = wb_val;
    else                                                  fwd_b = id_ex_b;
  end

  assign op_b = id_ex_alusrc ? id_ex_imm : fwd_b;

  // ALU
  always_comb begin
    case (id_ex_aluop)
      ALU_ADD: alu_out = fwd_a + op_b;
      ALU_SUB: alu_out = fwd_a - op_b;
      ALU_AND: alu_out = fwd_a & op_b;
      ALU_OR:  alu_out = fwd_a | op_b;
      ALU_SLT: alu_out = {31'd0, $signed(fwd_a) < $signed(op_b)};
      default: alu_out = 32'd0;
    endcase
  end

  assign overflow      = id_ex_ovf && ((id_ex_aluop == ALU_SUB) ? sub_ovf(fwd_a, op_b, alu_out)
                                                                : add_ovf(fwd_a, op_b, alu_out));
  assign exc           = id_ex_illegal || overflow;
  assign taken         = id_ex_branch && (fwd_a == fwd_b);
  assign branch_target = id_ex_pc + 32'd4 + {id_ex_imm[29:0], 2'b00};
  assign seq_pc        = ((pc + 32'd4) >= 32'(MEM_SIZE)) ? 32'd0 : (pc + 32'd4);

  // Next-PC selection: exception > taken beq > j > load-use hold > sequential.
  always_comb begin
    if (exc)           next_pc = 32'(ExceptionAddr);
    else if (taken)    next_pc = branch_target;
    else if (dec_jump) next_pc = jump_target;
    else if (stall)    next_pc = pc;
    else               next_pc = seq_pc;
  end

  // Pipeline registers, register file and EPC.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= 32'd0; if_id_instr <= 32'd0; if_id_pc <= 32'd0;
      id_ex_pc <= 32'd0; id_ex_a <= 32'd0; id_ex_b <= 32'd0; id_ex_imm <= 32'd0;
      id_ex_rs <= 5'd0; id_ex_rt <= 5'd0; id_ex_dst <= 5'd0; id_ex_aluop <= ALU_ADD;
      id_ex_memread <= 1'b0; id_ex_memwrite <= 1'b0; id_ex_branch <= 1'b0;
      id_ex_alusrc <= 1'b0; id_ex_ovf <= 1'b0; id_ex_illegal <= 1'b0;
      ex_mem_alu <= 32'd0; ex_mem_daddr <= 32'd0; ex_mem_ddata <= 32'd0; ex_mem_dst <= 5'd0;
      ex_mem_memread <= 1'b0; ex_mem_memwrite <= 1'b0;
      wb_rd <= 5'd0; wb_val <= 32'd0; epc <= 32'd0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      pc <= next_pc;

      if (exc || taken || dec_jump) begin
        if_id_instr <= 32'd0; if_id_pc <= 32'd0;
      end else if (!stall) begin
        if_id_instr <= Instruction; if_id_pc <= pc;
      end else begin
        if_id_instr <= if_id_instr; if_id_pc <= if_id_pc;
      end

      if (exc || taken || stall) begin
        id_ex_pc <= 32'd0; id_ex_a <= 32'd0; id_ex_b <= 32'd0; id_ex_imm <= 32'd0;
        id_ex_rs <= 5'd0; id_ex_rt <= 5'd0; id_ex_dst <= 5'd0; id_ex_aluop <= ALU_ADD;
        id_ex_memread <= 1'b0; id_ex_memwrite <= 1'b0; id_ex_branch <= 1'b0;
        id_ex_alusrc <= 1'b0; id_ex_ovf <= 1'b0; id_ex_illegal <= 1'b0;
      end else begin
        id_ex_pc <= if_id_pc; id_ex_a <= id_a; id_ex_b <= id_b; id_ex_imm <= id_imm;
        id_ex_rs <= id_rs; id_ex_rt <= id_rt; id_ex_dst <= dec_dst; id_ex_aluop <= dec_aluop;
        id_ex_memread <= dec_memread; id_ex_memwrite <= dec_memwrite; id_ex_branch <= dec_branch;
        id_ex_alusrc <= dec_alusrc; id_ex_ovf <= dec_ovf; id_ex_illegal <= dec_illegal;
      end

      if (exc) begin
        ex_mem_alu <= 32'd0; ex_mem_daddr <= 32'd0; ex_mem_ddata <= 32'd0; ex_mem_dst <= 5'd0;
        ex_mem_memread <= 1'b0; ex_mem_memwrite <= 1'b0;
        epc <= id_ex_pc;
      end else begin
        ex_mem_alu <= alu_out; ex_mem_dst <= id_ex_dst;
        ex_mem_memread <= id_ex_memread; ex_mem_memwrite <= id_ex_memwrite;
        ex_mem_daddr <= id_ex_memwrite ? alu_out : 32'd0;
        ex_mem_ddata <= id_ex_memwrite ? fwd_b : 32'd0;
        epc <= epc;
      end

      wb_rd <= ex_mem_dst;
      if (ex_mem_dst == 5'd0)  wb_val <= 32'd0;
      else if (ex_mem_memread) wb_val <= dmem[ex_mem_alu[7:2]];
      else                     wb_val <= ex_mem_alu;

      if (wb_rd != 5'd0) regs[wb_rd] <= wb_val;
    end
  end

  // Data memory write in MEM; an edge with reset high never stores.
  always_ff @(posedge clk) begin
    if (!reset && ex_mem_memwrite) dmem[ex_mem_daddr[7:2]] <= ex_mem_ddata;
  end

  assign PC              = pc;
  assign RegisterNo      = wb_rd;
  assign RegisterContent = wb_val;
  assign DataAddr        = ex_mem_daddr;
  assign Data            = ex_mem_ddata;

endmodule

// File: tb/tb_mips_pip_cpu.sv
// Directed testbench for mips_pip_cpu: small programs in a bench-side ROM,
// outputs sampled on the falling edge at hand-computed cycle numbers.
module tb_mips_pip_cpu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Instruction, PC, RegisterContent, DataAddr, Data;
  logic [4:0]  RegisterNo;
  logic [31:0] imem [128];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  assign Instruction = imem[PC[8:2]];

  mips_pip_cpu dut (
    .clk(clk), .reset(reset), .Instruction(Instruction), .PC(PC),
    .RegisterNo(RegisterNo), .RegisterContent(RegisterContent),
    .DataAddr(DataAddr), .Data(Data)
  );

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int funct);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
  endfunction
  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input int no, input logic [31:0] val);
    chk({tag, ".no"}, {27'd0, RegisterNo}, 32'(no));
    chk({tag, ".val"}, RegisterContent, val);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 128; i++) imem[i] = 32'd0;
  endtask

  task automatic goto_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
  endtask

  // Two reset edges, then release; cycle 0 is the one that presents PC=0.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    // T1: single addi, reset state and 4-cycle latency
    clear_imem();
    imem[0] = 32'h20050005;
    do_reset();
    chk("rst.pc", PC, 32'd0);
    chk_wb("rst.wb", 0, 32'd0);
    chk("rst.daddr", DataAddr, 32'd0);
    chk("rst.data", Data, 32'd0);
    goto_cycle(1); chk("t1.pc1", PC, 32'd4);
    goto_cycle(3); chk_wb("t1.c3", 0, 32'd0);
    goto_cycle(4); chk_wb("t1.c4", 5, 32'd5);

    // T2: back-to-back dependency via EX/MEM forwarding
    clear_imem();
    imem[0] = enc_i(8, 0, 1, 7);
    imem[1] = enc_r(1, 1, 2, 32'h20);
    do_reset();
    goto_cycle(4); chk_wb("t2.r1", 1, 32'd7);
    goto_cycle(5); chk_wb("t2.r2", 2, 32'd14);

    // T3: store, load, load-use stall
    clear_imem();
    imem[0] = enc_i(8, 0, 1, 8);
    imem[1] = enc_i(32'h2B, 0, 1, 4);
    imem[2] = enc_i(32'h23, 0, 3, 4);
    imem[3] = enc_r(3, 3, 4, 32'h20);
    do_reset();
    goto_cycle(4);
    chk("t3.daddr", DataAddr, 32'd4);
    chk("t3.data", Data, 32'd8);
    goto_cycle(5);
    chk("t3.pc_hold", PC, 32'd16);
    chk("t3.daddr_lw", DataAddr, 32'd0);
    goto_cycle(6);
    chk("t3.pc_go", PC, 32'd20);
    chk_wb("t3.r3", 3, 32'd8);
    goto_cycle(7); chk_wb("t3.bubble", 0, 32'd0);
    goto_cycle(8); chk_wb("t3.r4", 4, 32'd16);

    // T4: taken beq skips two instructions
    clear_imem();
    imem[0] = enc_i(4, 0, 0, 2);
    imem[1] = enc_i(8, 0, 1, 1);
    imem[2] = enc_i(8, 0, 2, 2);
    imem[3] = enc_i(8, 0, 3, 3);
    do_reset();
    goto_cycle(3); chk("t4.pc", PC, 32'd12);
    goto_cycle(4); chk_wb("t4.c4", 0, 32'd0);
    goto_cycle(5); chk_wb("t4.c5", 0, 32'd0);
    goto_cycle(6); chk_wb("t4.c6", 0, 32'd0);
    goto_cycle(7); chk_wb("t4.c7", 3, 32'd3);

    // T5: build 0x7FFFFFFF, then add 1 overflows into the handler
    clear_imem();
    imem[0] = enc_i(8, 0, 1, 32'h7FFF);
    for (int i = 1; i <= 16; i++) imem[i] = enc_r(1, 1, 1, 32'h20);
    imem[17] = enc_i(8, 1, 1, 32'h7FFF);
    imem[18] = enc_i(8, 1, 1, 32'h7FFF);
    imem[19] = enc_i(8, 1, 1, 1);
    imem[20] = enc_i(8, 0, 2, 1);
    imem[21] = enc_r(1, 2, 3, 32'h20);
    imem[22] = enc_i(8, 0, 4, 4);
    imem[23] = enc_i(8, 0, 5, 5);
    imem[98] = enc_i(8, 0, 6, 6);
    do_reset();
    goto_cycle(20); chk_wb("t5.dbl", 1, 32'h7FFF0000);
    goto_cycle(23); chk_wb("t5.max", 1, 32'h7FFFFFFF);
    goto_cycle(24);
    chk("t5.pc_exc", PC, 32'd392);
    chk_wb("t5.r2", 2, 32'd1);
    goto_cycle(25); chk_wb("t5.nowr", 0, 32'd0);
    goto_cycle(26); chk_wb("t5.fl1", 0, 32'd0);
    goto_cycle(27); chk_wb("t5.fl2", 0, 32'd0);
    chk("t5.epc", dut.epc, 32'd84);
    goto_cycle(28); chk_wb("t5.hdl", 6, 32'd6);

    // T6: illegal opcode at address 4
    clear_imem();
    imem[0] = enc_i(8, 0, 1, 1);
    imem[1] = 32'hFC000000;
    imem[2] = enc_i(8, 0, 2, 2);
    imem[3] = enc_i(8, 0, 3, 3);
    imem[98] = enc_i(8, 0, 6, 6);
    do_reset();
    chk("t6.epc_rst", dut.epc, 32'd0);
    goto_cycle(4);
    chk("t6.pc_exc", PC, 32'd392);
    chk_wb("t6.r1", 1, 32'd1);
    goto_cycle(5); chk_wb("t6.ill", 0, 32'd0);
    goto_cycle(6); chk_wb("t6.fl1", 0, 32'd0);
    goto_cycle(7); chk_wb("t6.fl2", 0, 32'd0);
    chk("t6.epc", dut.epc, 32'd4);
    goto_cycle(8); chk_wb("t6.hdl", 6, 32'd6);

    // T7: j resolved in ID, one slot flushed
    clear_imem();
    imem[0] = 32'h08000010;
    imem[1] = enc_i(8, 0, 1, 1);
    imem[16] = enc_i(8, 0, 7, 7);
    do_reset();
    goto_cycle(2); chk("t7.pc", PC, 32'h40);
    goto_cycle(5); chk_wb("t7.fl", 0, 32'd0);
    goto_cycle(6); chk_wb("t7.tgt", 7, 32'd7);

    // T8: PC wraps from the last word back to 0
    clear_imem();
    imem[0] = 32'h0800007F;
    imem[127] = enc_i(8, 0, 1, 1);
    do_reset();
    goto_cycle(2); chk("t8.pc_last", PC, 32'd508);
    goto_cycle(3); chk("t8.pc_wrap", PC, 32'd0);
    goto_cycle(4); chk("t8.pc_next", PC, 32'd4);
    goto_cycle(6); chk_wb("t8.r1", 1, 32'd1);

    // T9: reset mid-program while a store sits in MEM
    clear_imem();
    imem[0] = enc_i(8, 0, 1, 9);
    imem[1] = enc_i(32'h2B, 0, 1, 8);
    do_reset();
    goto_cycle(4);
    chk("t9.daddr", DataAddr, 32'd8);
    chk("t9.data", Data, 32'd9);
    chk_wb("t9.r1", 1, 32'd9);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("t9.pc", PC, 32'd0);
    chk_wb("t9.wb", 0, 32'd0);
    chk("t9.daddr0", DataAddr, 32'd0);
    chk("t9.data0", Data, 32'd0);

    // T10: discarded store left memory alone, earlier store survived, regs cleared
    clear_imem();
    imem[0] = enc_i(32'h23, 0, 2, 8);
    imem[1] = enc_i(32'h23, 0, 3, 4);
    imem[2] = enc_r(1, 1, 4, 32'h20);
    do_reset();
    goto_cycle(4); chk_wb("t10.r2", 2, 32'd0);
    goto_cycle(5); chk_wb("t10.r3", 3, 32'd8);
    goto_cycle(6); chk_wb("t10.r4", 4, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
